// File: rtl/uart_mmio_pkg.sv
// uart_mmio shared definitions: register offsets,
// STATUS bit positions and the poll FSM states.
package uart_mmio_pkg;

   localparam logic UART_DATA_OFS = 1'b0;
   localparam logic UART_STAT_OFS = 1'b1;

   localparam int ST_TX_FULL  = 0;
   localparam int ST_TX_EMPTY = 1;
   localparam int ST_RX_VALID = 2;
   localparam int ST_RX_OVR   = 3;
   localparam int ST_TX_DROP  = 4;

   localparam logic [7:0] UART_NOCHAR = 8'hFF;

   typedef enum logic {
      ST_WAIT,
      ST_POLL
   } poll_st_e;

endpackage

// File: rtl/uart_mmio_fifo.sv
// Synchronous FIFO, first-word fall-through; a push while
// full is taken only when a pop happens in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_q, wr_d;
   logic [AW:0]      rd_q, rd_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty_o = (wr_q == rd_q);
   assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                    (wr_q[AW-1:0] == rd_q[AW-1:0]);

   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);
   assign dout_o  = mem_q[rd_q[AW-1:0]];

   always_comb begin
      wr_d = wr_q + (AW+1)'(do_push);
      rd_d = rd_q + (AW+1)'(do_pop);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
   end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped UART: CPU stores drain to the console port,
// console polls fill an RX buffer for CPU loads.
module uart_mmio
   import uart_mmio_pkg::*;
#(
   parameter int TX_DEPTH = 16,
   parameter int RX_DEPTH = 8,
   parameter int TX_GAP   = 4,
   parameter int POLL_GAP = 64
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        ce,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [3:0]  sel,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        uart_out_valid,
   output logic [7:0]  uart_out_ch,
   output logic        uart_in_valid,
   input  logic [7:0]  uart_in_ch
);

   localparam int GW = $clog2(TX_GAP + 1);
   localparam int PW = $clog2(POLL_GAP + 1);

   logic          rd_en, wr_en, is_stat;
   logic          tx_full, tx_empty, tx_pop;
   logic          tx_push_req, stat_clr;
   logic [7:0]    tx_dout;
   logic          rx_full, rx_empty, rx_pop;
   logic          rx_push, poll_hit;
   logic [7:0]    rx_dout;
   logic [31:0]   status;
   logic          unused_bits;

   logic [GW-1:0] gap_q, gap_d;
   logic          ov_q, ov_d;
   logic [7:0]    och_q, och_d;
   logic          drop_q, drop_d;
   logic          ovr_q, ovr_d;
   logic [31:0]   rdata_q, rdata_d;
   poll_st_e      state_q;
   logic [PW-1:0] poll_q;

   assign rd_en   = ce & ~we;
   assign wr_en   = ce & we;
   assign is_stat = (addr[2] == UART_STAT_OFS);

   assign tx_push_req = wr_en & ~is_stat & sel[0];
   assign tx_pop      = (gap_q == '0) & ~tx_empty;
   assign stat_clr    = wr_en & is_stat & sel[0];

   assign rx_pop   = rd_en & ~is_stat & ~rx_empty;
   assign poll_hit = (state_q == ST_POLL) &&
                     (uart_in_ch != UART_NOCHAR);
   assign rx_push  = poll_hit & (~rx_full | rx_pop);

   assign unused_bits = ^{addr[31:3], addr[1:0],
                          sel[3:1], wdata[31:8]};

   sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx (
      .clk_i  (clock),
      .rst_ni (reset_n),
      .push_i (tx_push_req),
      .din_i  (wdata[7:0]),
      .pop_i  (tx_pop),
      .dout_o (tx_dout),
      .full_o (tx_full),
      .empty_o(tx_empty)
   );

   sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx (
      .clk_i  (clock),
      .rst_ni (reset_n),
      .push_i (rx_push),
      .din_i  (uart_in_ch),
      .pop_i  (rx_pop),
      .dout_o (rx_dout),
      .full_o (rx_full),
      .empty_o(rx_empty)
   );

   always_comb begin
      status              = '0;
      status[ST_TX_FULL]  = tx_full;
      status[ST_TX_EMPTY] = tx_empty;
      status[ST_RX_VALID] = ~rx_empty;
      status[ST_RX_OVR]   = ovr_q;
      status[ST_TX_DROP]  = drop_q;
   end

   always_comb begin
      gap_d = gap_q;
      if (tx_pop) gap_d = GW'(TX_GAP - 1);
      else if (gap_q != '0) gap_d = gap_q - 1'b1;

      ov_d  = tx_pop;
      och_d = tx_pop ? tx_dout : och_q;

      // sticky sets win over a same-cycle clear
      drop_d = (drop_q & ~(stat_clr & wdata[ST_TX_DROP]))
             | (tx_push_req & tx_full & ~tx_pop);
      ovr_d  = (ovr_q & ~(stat_clr & wdata[ST_RX_OVR]))
             | (poll_hit & rx_full & ~rx_pop);

      rdata_d = rdata_q;
      if (rd_en) begin
         if (is_stat)       rdata_d = status;
         else if (rx_empty) rdata_d = '0;
         else               rdata_d = {24'b0, rx_dout};
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         gap_q   <= '0;
         ov_q    <= 1'b0;
         och_q   <= '0;
         drop_q  <= 1'b0;
         ovr_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         gap_q   <= gap_d;
         ov_q    <= ov_d;
         och_q   <= och_d;
         drop_q  <= drop_d;
         ovr_q   <= ovr_d;
         rdata_q <= rdata_d;
      end
   end

   // polls are only issued while RX has room
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= ST_WAIT;
         poll_q  <= '0;
      end else begin
         unique case (state_q)
            ST_WAIT: begin
               if (poll_q == '0) begin
                  poll_q <= PW'(POLL_GAP - 1);
                  if (!rx_full) state_q <= ST_POLL;
               end else begin
                  poll_q <= poll_q - 1'b1;
               end
            end
            ST_POLL: begin
               state_q <= ST_WAIT;
               poll_q  <= PW'(POLL_GAP - 1);
            end
         endcase
      end
   end

   assign rdata          = rdata_q;
   assign uart_out_valid = ov_q;
   assign uart_out_ch    = och_q;
   assign uart_in_valid  = (state_q == ST_POLL);

endmodule

// File: tb/tb_uart_mmio.sv
// Directed bench for uart_mmio: register table plus
// TX ordering/overflow, RX polling and reset sequences.
module tb_uart_mmio;

   logic        clock;
   logic        reset_n;
   logic        ce;
   logic        we;
   logic [31:0] addr;
   logic [3:0]  sel;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        uart_out_valid;
   logic [7:0]  uart_out_ch;
   logic        uart_in_valid;
   logic [7:0]  uart_in_ch;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int in_cnt = 0;
   logic [7:0] out_q [$];
   int         out_t [$];

   typedef struct {
      logic        c;
      logic        w;
      logic        a2;
      logic [3:0]  s;
      logic [31:0] d;
      logic        chk;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl [11];

   uart_mmio dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .ce            (ce),
      .we            (we),
      .addr          (addr),
      .sel           (sel),
      .wdata         (wdata),
      .rdata         (rdata),
      .uart_out_valid(uart_out_valid),
      .uart_out_ch   (uart_out_ch),
      .uart_in_valid (uart_in_valid),
      .uart_in_ch    (uart_in_ch)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      if (uart_out_valid === 1'b1) begin
         out_q.push_back(uart_out_ch);
         out_t.push_back(cyc);
      end
      if (uart_in_valid === 1'b1) in_cnt++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      ce = 1'b0;
      we = 1'b0;
      sel = 4'h0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic op(input logic c, input logic w,
                     input logic a2, input logic [3:0] s,
                     input logic [31:0] d);
      ce = c;
      we = w;
      addr = {29'b0, a2, 2'b0};
      sel = s;
      wdata = d;
      tick();
      ce = 1'b0;
      we = 1'b0;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", nm, act, exp);
      end
   endtask

   task automatic rd_stat(input string nm, input logic [31:0] exp);
      op(1'b1, 1'b0, 1'b1, 4'h0, 32'h0);
      chk(nm, rdata, exp);
   endtask

   initial begin
      int n;
      int base;

      tbl[0]  = '{1'b1, 1'b0, 1'b1, 4'h0, 32'h0,        1'b1, 32'h2};
      tbl[1]  = '{1'b1, 1'b1, 1'b0, 4'hE, 32'h55,       1'b1, 32'h2};
      tbl[2]  = '{1'b1, 1'b0, 1'b1, 4'h0, 32'h0,        1'b1, 32'h2};
      tbl[3]  = '{1'b1, 1'b0, 1'b0, 4'h0, 32'h0,        1'b1, 32'h0};
      tbl[4]  = '{1'b0, 1'b1, 1'b0, 4'hF, 32'h77,       1'b1, 32'h0};
      tbl[5]  = '{1'b1, 1'b0, 1'b1, 4'h0, 32'h0,        1'b1, 32'h2};
      tbl[6]  = '{1'b1, 1'b1, 1'b0, 4'h1, 32'h5A,       1'b0, 32'h0};
      tbl[7]  = '{1'b1, 1'b0, 1'b1, 4'h0, 32'h0,        1'b1, 32'h0};
      tbl[8]  = '{1'b1, 1'b0, 1'b1, 4'h0, 32'h0,        1'b1, 32'h2};
      tbl[9]  = '{1'b1, 1'b1, 1'b1, 4'hF, 32'hFFFFFFFF, 1'b0, 32'h0};
      tbl[10] = '{1'b1, 1'b0, 1'b1, 4'h0, 32'h0,        1'b1, 32'h2};

      // reset held with a DATA write pending
      reset_n = 1'b0;
      ce = 1'b1;
      we = 1'b1;
      addr = 32'h0;
      sel = 4'hF;
      wdata = 32'h41;
      uart_in_ch = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_rdata", rdata, 32'h0);
         chk("rst_in_valid", {31'b0, uart_in_valid}, 32'h0);
      end
      ce = 1'b0;
      reset_n = 1'b1;
      idle(3);
      chk("rst_no_tx", out_q.size(), 0);
      rd_stat("rst_status", 32'h2);

      out_q.delete();
      out_t.delete();
      for (int i = 0; i < 11; i++) begin
         op(tbl[i].c, tbl[i].w, tbl[i].a2, tbl[i].s, tbl[i].d);
         if (tbl[i].chk) chk($sformatf("tbl[%0d]", i), rdata, tbl[i].exp);
      end
      idle(4);
      chk("tbl_tx_count", out_q.size(), 1);
      if (out_q.size() > 0) chk("tbl_tx_char", {24'b0, out_q[0]}, 32'h5A);

      // TX order and spacing
      idle(8);
      out_q.delete();
      out_t.delete();
      op(1'b1, 1'b1, 1'b0, 4'h1, 32'h48);
      op(1'b1, 1'b1, 1'b0, 4'h1, 32'h69);
      op(1'b1, 1'b1, 1'b0, 4'h1, 32'h21);
      idle(20);
      chk("hi_count", out_q.size(), 3);
      if (out_q.size() == 3) begin
         chk("hi_ch0", {24'b0, out_q[0]}, 32'h48);
         chk("hi_ch1", {24'b0, out_q[1]}, 32'h69);
         chk("hi_ch2", {24'b0, out_q[2]}, 32'h21);
         chk("hi_gap1", out_t[1] - out_t[0], 4);
         chk("hi_gap2", out_t[2] - out_t[1], 4);
      end
      rd_stat("hi_status", 32'h2);

      // 23 back-to-back writes: #22 rides a concurrent pop, #23 drops
      idle(8);
      out_q.delete();
      out_t.delete();
      for (int i = 0; i < 23; i++) op(1'b1, 1'b1, 1'b0, 4'h1, i);
      rd_stat("ovf_full_drop", 32'h11);
      op(1'b1, 1'b1, 1'b1, 4'h1, 32'h10);
      rd_stat("ovf_clr_drop", 32'h01);
      idle(100);
      chk("ovf_count", out_q.size(), 22);
      for (int i = 0; i < out_q.size(); i++) begin
         chk($sformatf("ovf_ch%0d", i), {24'b0, out_q[i]}, i);
         if (i > 0) chk($sformatf("ovf_gap%0d", i), out_t[i] - out_t[i-1], 4);
      end
      rd_stat("ovf_status", 32'h2);

      // RX poll: no-char then 0x0A
      uart_in_ch = 8'hFF;
      n = 0;
      while (!uart_in_valid && n < 100) begin
         tick();
         n++;
      end
      chk("poll1_seen", {31'b0, uart_in_valid}, 32'h1);
      tick();
      uart_in_ch = 8'h0A;
      n = 1;
      while (!uart_in_valid && n < 200) begin
         tick();
         n++;
      end
      chk("poll_period", n, 65);
      rd_stat("poll_rx_empty", 32'h2);
      uart_in_ch = 8'hFF;
      rd_stat("poll_rx_valid", 32'h6);
      op(1'b1, 1'b0, 1'b0, 4'h0, 32'h0);
      chk("poll_read", rdata, 32'h0A);
      rd_stat("poll_rx_drained", 32'h2);

      // RX fills to 8 and polling stops
      uart_in_ch = 8'h30;
      n = 0;
      while (!uart_in_valid && n < 100) begin
         tick();
         n++;
      end
      chk("full_first_poll", {31'b0, uart_in_valid}, 32'h1);
      base = in_cnt;
      idle(650);
      chk("full_poll_count", in_cnt - base, 8);
      rd_stat("full_status", 32'h6);
      op(1'b1, 1'b0, 1'b0, 4'h0, 32'h0);
      chk("full_read", rdata, 32'h30);
      n = 0;
      while (!uart_in_valid && n < 70) begin
         tick();
         n++;
      end
      chk("full_resume", {31'b0, uart_in_valid}, 32'h1);
      tick();
      uart_in_ch = 8'hFF;
      for (int i = 0; i < 8; i++) begin
         op(1'b1, 1'b0, 1'b0, 4'h0, 32'h0);
         chk($sformatf("full_drain%0d", i), rdata, 32'h30);
      end
      op(1'b1, 1'b0, 1'b0, 4'h0, 32'h0);
      chk("empty_read", rdata, 32'h0);
      rd_stat("empty_status", 32'h2);

      // reset in the middle of a drain
      idle(8);
      out_q.delete();
      out_t.delete();
      op(1'b1, 1'b1, 1'b0, 4'h1, 32'h41);
      op(1'b1, 1'b1, 1'b0, 4'h1, 32'h42);
      op(1'b1, 1'b1, 1'b0, 4'h1, 32'h43);
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      chk("mid_rst_ch", {24'b0, uart_out_ch}, 32'h0);
      chk("mid_rst_valid", {31'b0, uart_out_valid}, 32'h0);
      idle(20);
      chk("mid_rst_count", out_q.size(), 1);
      rd_stat("mid_rst_status", 32'h2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
